// File: rtl/slave_mem_sp.sv
// slave_mem_sp: parametrised serial-bus memory slave with split-read support.
// The slave shifts in an LSB-first address, acknowledges legal addresses,
// then either shifts in a write word or shifts out a read word.
// Build option: define SLAVE_MEM_SPLIT_EN to build the SPLIT_WAIT/SPLIT_REQ
// path. Without it reads always go straight from ACK_A to READ.
// Assumes ADDR_W >= 2, DATA_W >= 2 and ADDR_W >= clog2(MEM_DEPTH).
module slave_mem_sp #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096,
    parameter int SPLIT_LAT = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              AD_SEL,
    input  logic              B_BUS_OUT,
    input  logic              B_RW,
    input  logic              B_SPL_RESUME,
    output logic              B_BUS_IN,
    output logic              B_ACK,
    output logic              B_SBSY,
    output logic              B_SPL_REQ,
    output logic              S_DVALID,
    output logic [DATA_W-1:0] S_DOUT,
    output logic [ADDR_W-1:0] S_ADDR
);

    // Counter covers the longest phase: address, data or split latency.
    localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_ALL = (MAX_AD > SPLIT_LAT) ? MAX_AD : SPLIT_LAT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

`ifdef SLAVE_MEM_SPLIT_EN
    localparam bit               SPLIT_ON   = (SPLIT_LAT > 0);
    localparam logic [CNT_W-1:0] SPLIT_LAST = CNT_W'((SPLIT_LAT > 0) ? SPLIT_LAT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_WRITE,
        ST_ACK_W,
        ST_READ,
        ST_SPLIT_WAIT,
        ST_SPLIT_REQ
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_WRITE,
        ST_ACK_W,
        ST_READ
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              bus_in_q, bus_in_d;
    logic              dvalid_q, dvalid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
`ifdef SLAVE_MEM_SPLIT_EN
    logic              sbsy_q, sbsy_d;
    logic              spl_req_q, spl_req_d;
`endif

    // Shift-register views with the incoming serial bit placed at the MSB;
    // after the full count the first bit received ends up at bit 0.
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    assign addr_next = {B_BUS_OUT, addr_q[ADDR_W-1:1]};
    assign data_next = {B_BUS_OUT, data_q[DATA_W-1:1]};

    // Memory array: no reset, one write port, registered read.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_word_q;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_we;
    assign mem_idx = addr_q[IDX_W-1:0];

    // Word store on the final write bit, and continuous read of the
    // addressed word so it is ready by the time READ is entered.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_idx] <= data_next;
        end
        rd_word_q <= mem[mem_idx];
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        bus_in_d = 1'b0;
        dvalid_d = 1'b0;
        dout_d   = dout_q;
        saddr_d  = saddr_q;
        mem_we   = 1'b0;
`ifdef SLAVE_MEM_SPLIT_EN
        sbsy_d    = 1'b0;
        spl_req_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                cnt_d  = '0;
                if (AD_SEL) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!AD_SEL) begin
                    // Deselected mid-address: abandon silently.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_next;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if ({1'b0, addr_next} < DEPTH_EXT) begin
                            state_d = ST_ACK_A;
                            ack_d   = 1'b1;
                        end else begin
                            // Out-of-range address: NAK by never acking.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACK_A: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                    ack_d = 1'b1;
                end else begin
                    cnt_d = '0;
                    if (B_RW) begin
                        state_d = ST_WRITE;
                        data_d  = '0;
                    end else begin
`ifdef SLAVE_MEM_SPLIT_EN
                        if (SPLIT_ON) begin
                            state_d = ST_SPLIT_WAIT;
                            sbsy_d  = 1'b1;
                        end else begin
                            state_d  = ST_READ;
                            bus_in_d = rd_word_q[0];
                            data_d   = rd_word_q >> 1;
                        end
`else
                        state_d  = ST_READ;
                        bus_in_d = rd_word_q[0];
                        data_d   = rd_word_q >> 1;
`endif
                    end
                end
            end
            ST_WRITE: begin
                data_d = data_next;
                if (cnt_q == DATA_LAST) begin
                    // The word is committed only once the last bit is in.
                    mem_we  = 1'b1;
                    state_d = ST_ACK_W;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK_W: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                    ack_d = 1'b1;
                end else begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    dvalid_d = 1'b1;
                    dout_d   = data_q;
                    saddr_d  = addr_q;
                end
            end
            ST_READ: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    bus_in_d = data_q[0];
                    data_d   = data_q >> 1;
                end
            end
`ifdef SLAVE_MEM_SPLIT_EN
            ST_SPLIT_WAIT: begin
                // The B_SBSY cycle counts as the first latency cycle.
                if (cnt_q == SPLIT_LAST) begin
                    state_d   = ST_SPLIT_REQ;
                    spl_req_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SPLIT_REQ: begin
                if (B_SPL_RESUME) begin
                    state_d  = ST_READ;
                    bus_in_d = rd_word_q[0];
                    data_d   = rd_word_q >> 1;
                end else begin
                    spl_req_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            bus_in_q  <= 1'b0;
            dvalid_q  <= 1'b0;
            dout_q    <= '0;
            saddr_q   <= '0;
`ifdef SLAVE_MEM_SPLIT_EN
            sbsy_q    <= 1'b0;
            spl_req_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            bus_in_q  <= bus_in_d;
            dvalid_q  <= dvalid_d;
            dout_q    <= dout_d;
            saddr_q   <= saddr_d;
`ifdef SLAVE_MEM_SPLIT_EN
            sbsy_q    <= sbsy_d;
            spl_req_q <= spl_req_d;
`endif
        end
    end

    assign B_ACK    = ack_q;
    assign B_BUS_IN = bus_in_q;
    assign S_DVALID = dvalid_q;
    assign S_DOUT   = dout_q;
    assign S_ADDR   = saddr_q;

`ifdef SLAVE_MEM_SPLIT_EN
    assign B_SBSY    = sbsy_q;
    assign B_SPL_REQ = spl_req_q;
`else
    // Split path not built: notifications stay low, resume has no effect.
    logic unused_resume;
    assign unused_resume = B_SPL_RESUME;
    assign B_SBSY        = 1'b0;
    assign B_SPL_REQ     = 1'b0;
`endif

endmodule

// File: doc/slave_mem_sp.md
# slave_mem_sp

Parametrised serial-bus memory slave with split-transaction support; successor to the fixed 4 KB split slave. Sits on the serial system bus behind the address decoder (AD_SEL). It receives a serial address and write data from the master and returns serial read data. It models a slow memory through a configurable read latency: the bus is released with B_SBSY, and the slave requests resumption with B_SPL_REQ once the data is ready.

## Interface
- ADDR_W, 16, serial address bits shifted in per transaction
- DATA_W, 8, word width in bits
- MEM_DEPTH, 4096, number of words; legal addresses 0..MEM_DEPTH-1
- SPLIT_LAT, 4, read latency in cycles; 0 disables split even when compiled in
- CLK  in  1  bus clock, all logic on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- AD_SEL  in  1  slave selected by decoder; must stay high through ADDR
- B_BUS_OUT  in  1  serial master→slave line (address, write data), LSB first
- B_RW  in  1  1=write, 0=read; sampled in last ACK_A cycle
- B_SPL_RESUME  in  1  arbiter grants bus back to this slave
- B_BUS_IN  out  1  serial slave→master read data, LSB first
- B_ACK  out  1  acknowledge
- B_SBSY  out  1  one-cycle split notification to arbiter
- B_SPL_REQ  out  1  split data ready, requesting bus
- S_DVALID  out  1  one-cycle strobe: a write committed
- S_DOUT  out  DATA_W  last written word
- S_ADDR  out  ADDR_W  address of last written word

## Operation
- States: IDLE, ADDR, ACK_A, WRITE, ACK_W, SPLIT_WAIT, SPLIT_REQ, READ.
- IDLE: AD_SEL=1 → ADDR. The address shift register clears in IDLE.
- ADDR: ADDR_W cycles; the bit in cycle i goes to addr[i].
  - AD_SEL=0 in any ADDR cycle → IDLE, no ACK.
  - After the last bit: addr<MEM_DEPTH → ACK_A; otherwise → IDLE, no ACK (NAK by silence).
- ACK_A: B_ACK=1 for 2 cycles. In the 2nd cycle B_RW is sampled:
  - B_RW=1 → WRITE.
  - B_RW=0 → READ, or SPLIT_WAIT when split is active.
- WRITE: DATA_W cycles shifting B_BUS_OUT into the data register, LSB first. The memory word is written once, in the last bit cycle; no partial-bit writes.
- ACK_W: B_ACK=1 for 2 cycles. In the cycle after ACK_W: S_DVALID=1 for one cycle, S_DOUT=written word, S_ADDR=addr. Then → IDLE. S_DOUT and S_ADDR hold their value until the next write.
- READ: DATA_W cycles, B_BUS_IN=mem[addr][i] in cycle i. After the last bit → IDLE. B_BUS_IN=0 outside READ.
- SPLIT_WAIT:
  - Entry cycle: B_SBSY=1 for exactly one cycle.
  - Counts SPLIT_LAT cycles, then → SPLIT_REQ.
- SPLIT_REQ:
  - B_SPL_REQ=1, held until B_SPL_RESUME=1.
  - In that cycle → READ and B_SPL_REQ drops next cycle.
  - B_SPL_RESUME arriving before SPLIT_REQ is ignored.
- Memory: read data is taken from the word latched at READ entry. The memory array is not reset; contents are undefined until written.
- The counter width is the clog2 of max(ADDR_W, DATA_W, SPLIT_LAT)+1.

## Timing
- Reset value of every output is 0, and state is IDLE. The counter and address/data registers are 0.
- Reset asserted mid-transaction aborts immediately. No memory write occurs unless the WRITE last-bit edge has already passed.
- AD_SEL sampled high at edge t → first address bit sampled at edge t+1.
- Unsplit write, from AD_SEL edge to S_DVALID: 1+ADDR_W+2+DATA_W+2 cycles.
- Unsplit read: first data bit on B_BUS_IN in the cycle after the 2nd ACK_A cycle.
- Split read:
  - B_SBSY is in the cycle after the 2nd ACK_A cycle.
  - B_SPL_REQ rises SPLIT_LAT cycles after the B_SBSY cycle.
  - The first data bit comes in the cycle after B_SPL_RESUME is sampled high.
- AD_SEL is ignored outside IDLE/ADDR. A new transaction needs one IDLE cycle.

## Configuration
- SLAVE_MEM_SPLIT_EN defined: SPLIT_WAIT/SPLIT_REQ logic is built. Reads split when SPLIT_LAT>0.
- Not defined: both states are removed. B_SBSY and B_SPL_REQ are tied 0, B_SPL_RESUME is ignored, and reads always go ACK_A→READ directly.

## Test plan
- Write 0xA5 to address 0x0010 → B_ACK 2 cycles after address, 2 cycles after data; S_DVALID=1 one cycle with S_DOUT=0xA5, S_ADDR=0x0010.
- Split build, SPLIT_LAT=4: read 0x0010 after the write above → B_SBSY one cycle, B_SPL_REQ 4 cycles later. Hold resume off 10 cycles → B_SPL_REQ stays high. Pulse B_SPL_RESUME → B_BUS_IN shows 1,0,1,0,0,1,0,1.
- Address 0x1000 (=MEM_DEPTH) → B_ACK never asserts; returns to IDLE; a following legal write succeeds.
- AD_SEL dropped at address bit 5 → no B_ACK, IDLE; memory unchanged.
- RSTN low during WRITE bit 3 → all outputs 0 immediately; S_DVALID never pulses; a later read of that address returns the prior value.
- Non-split build or SPLIT_LAT=0: read → B_SBSY/B_SPL_REQ stay 0; data starts in the cycle after ACK_A.
